// File: rtl/split_every3.sv
// split_every3: serialises each 3*DW-bit input word into three DW-bit beats, lane 0 first.
module split_every3 #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_dval,
    output logic            i_rdy,
    input  logic [3*DW-1:0] i,
    output logic            o_dval,
    input  logic            o_rdy,
    output logic [DW-1:0]   o,
    output logic            o_last
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t          state, state_nx;
    logic [1:0]      cnt, cnt_nx;
    logic [3*DW-1:0] word, word_nx;
    logic            acc, beat;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            word  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            word  <= word_nx;
        end
    end
    // The last beat hands over to the next word on the same edge, so i_rdy follows o_rdy.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        word_nx  = word;
        o_dval   = state == EMIT;
        o_last   = state == EMIT && cnt == 2'd2;
        i_rdy    = state == IDLE || (cnt == 2'd2 && o_rdy);
        acc      = i_dval && i_rdy;
        beat     = o_dval && o_rdy;
        o        = state != EMIT ? '0 :
                   cnt == 2'd0 ? word[DW-1:0] :
                   cnt == 2'd1 ? word[2*DW-1:DW] : word[3*DW-1:2*DW];
        if (acc) begin
            state_nx = EMIT;
            cnt_nx   = 2'd0;
            word_nx  = i;
        end else if (beat) begin
            state_nx = cnt == 2'd2 ? IDLE : EMIT;
            cnt_nx   = cnt == 2'd2 ? 2'd0 : cnt + 2'd1;
        end
    end
endmodule

// File: tb/tb_split_every3.sv
// tb_split_every3: directed scenarios plus random traffic checked against a lane-queue model.
module tb_split_every3;
    localparam int DW = 8;
    logic            clk, rst, i_dval, i_rdy, o_dval, o_rdy, o_last;
    logic [3*DW-1:0] i;
    logic [DW-1:0]   o;
    logic [DW-1:0]   q[$];
    int              total = 0, bad = 0;

    split_every3 #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .i_dval(i_dval), .i_rdy(i_rdy), .i(i),
        .o_dval(o_dval), .o_rdy(o_rdy), .o(o), .o_last(o_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag);
        logic          e_dv, e_last, e_rdy;
        logic [DW-1:0] e_o;
        e_dv   = q.size() != 0;
        e_o    = q.size() != 0 ? q[0] : '0;
        e_last = q.size() == 1;
        e_rdy  = q.size() == 0 || (q.size() == 1 && o_rdy);
        total += 4;
        assert (o_dval === e_dv) else begin bad++; $error("FAIL %s o_dval got=%0b exp=%0b", tag, o_dval, e_dv); end
        assert (o === e_o) else begin bad++; $error("FAIL %s o got=%h exp=%h", tag, o, e_o); end
        assert (o_last === e_last) else begin bad++; $error("FAIL %s o_last got=%0b exp=%0b", tag, o_last, e_last); end
        assert (i_rdy === e_rdy) else begin bad++; $error("FAIL %s i_rdy got=%0b exp=%0b", tag, i_rdy, e_rdy); end
    endtask

    // One clock: drive, check before the edge, then advance the model with what the edge sees.
    task automatic cyc(input string tag, input logic dv, input logic [3*DW-1:0] w, input logic ordy);
        logic bt, ac;
        i_dval = dv;
        i      = w;
        o_rdy  = ordy;
        #1;
        chk(tag);
        bt = q.size() != 0 && ordy;
        ac = dv && (q.size() == 0 || (q.size() == 1 && ordy));
        @(posedge clk);
        if (!rst) q.delete();
        else begin
            if (bt) void'(q.pop_front());
            if (ac) begin
                q.push_back(w[DW-1:0]);
                q.push_back(w[2*DW-1:DW]);
                q.push_back(w[3*DW-1:2*DW]);
            end
        end
        #1;
    endtask

    task automatic arst(input string tag);
        #2 rst = 1'b0;
        #1 q.delete();
        chk(tag);
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; i_dval = 1'b0; i = '0; o_rdy = 1'b1;
        #1 rst = 1'b0;
        #1 chk("pre_clk_reset");
        repeat (5) cyc("in_reset", 1'b1, 24'hABCDEF, 1'b1);
        rst = 1'b1;
        cyc("single_acc", 1'b1, 24'h030201, 1'b1);
        repeat (4) cyc("single", 1'b0, 24'h0, 1'b1);
        repeat (3) cyc("b2b_w0", 1'b1, 24'h030201, 1'b1);
        repeat (3) cyc("b2b_w1", 1'b1, 24'h060504, 1'b1);
        repeat (2) cyc("b2b_drain", 1'b0, 24'h0, 1'b1);
        cyc("stall_acc", 1'b1, 24'h030201, 1'b1);
        cyc("stall_l0", 1'b0, 24'h0, 1'b1);
        repeat (4) cyc("stall_l1", 1'b0, 24'h0, 1'b0);
        repeat (3) cyc("stall_rel", 1'b0, 24'h0, 1'b1);
        cyc("l2s_acc", 1'b1, 24'h030201, 1'b1);
        repeat (2) cyc("l2s_l01", 1'b0, 24'h0, 1'b1);
        repeat (3) cyc("l2s_hold", 1'b1, 24'h090807, 1'b0);
        repeat (5) cyc("l2s_rel", 1'b0, 24'h0, 1'b1);
        cyc("rst_acc", 1'b1, 24'h030201, 1'b1);
        cyc("rst_l0", 1'b0, 24'h0, 1'b1);
        arst("rst_mid");
        cyc("rst_new", 1'b1, 24'h0C0B0A, 1'b1);
        repeat (4) cyc("rst_beats", 1'b0, 24'h0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            cyc("rand", $urandom_range(0, 2) != 0, 24'($urandom), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) arst("rand_rst");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/split_every3.md
SPLIT_EVERY3 -- requirements
Module: split_every3

Interface
REQ-001 SHALL have parameter DW, default 8, giving the output lane width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_dval, input, 1 bit: input word valid.
REQ-005 SHALL have port i_rdy, output, 1 bit: block can accept an input word this cycle.
REQ-006 SHALL have port i, input, 3*DW bits: packed word; lane 0 = i[DW-1:0], lane 1 = i[2*DW-1:DW], lane 2 = i[3*DW-1:2*DW].
REQ-007 SHALL have port o_dval, output, 1 bit: output lane valid.
REQ-008 SHALL have port o_rdy, input, 1 bit: downstream accepts the output lane this cycle.
REQ-009 SHALL have port o, output, DW bits: current output lane.
REQ-010 SHALL have port o_last, output, 1 bit: high with the lane-2 beat of each word.

Function
REQ-011 SHALL accept an input word on any rising edge where i_dval && i_rdy; otherwise i is ignored.
REQ-012 SHALL emit each accepted word as three output beats, in the order lane 0, lane 1, lane 2.
REQ-013 SHALL transfer an output beat on any rising edge where o_dval && o_rdy.
REQ-014 SHALL implement two states: IDLE (no word held) and EMIT (word held in a 3*DW register, 2-bit lane counter cnt in 0..2).
REQ-015 SHALL go IDLE->EMIT on accept, loading the register with i and setting cnt=0.
REQ-016 SHALL, in EMIT, advance cnt by 1 on a beat transfer with cnt<2.
REQ-017 SHALL, in EMIT, on a beat transfer with cnt==2: reload the register and set cnt=0 if an input is accepted on the same edge, else go to IDLE.
REQ-018 SHALL drive o_dval=1 exactly in EMIT; o = lane cnt of the register; o_last = (cnt==2) in EMIT, else 0.
REQ-019 SHALL drive i_rdy = IDLE || (EMIT && cnt==2 && o_rdy), combinational from o_rdy.
REQ-020 SHALL place the first beat of a word on o in the cycle after the accepting edge (latency 1).
REQ-021 SHALL sustain one word per 3 cycles with no bubbles when i_dval and o_rdy are held high.
REQ-022 SHALL hold o, o_last and o_dval stable while o_dval=1 and o_rdy=0.
REQ-023 SHALL drive o=0 while IDLE; the register is not cleared on return to IDLE.
REQ-024 SHALL neither drop nor duplicate lanes; cnt never exceeds 2.

Reset
REQ-025 SHALL, while rst=0 and independently of clk, force state IDLE, cnt=0, register=0, o_dval=0, o=0 and o_last=0.
REQ-026 SHALL drive i_rdy=1 from reset, since the block is IDLE.
REQ-027 SHALL, on reset mid-word, discard all remaining lanes; the first accept after rst returns high starts at lane 0.

Verification
REQ-028 SHALL be covered by this scenario: rst low for 5 cycles -> o_dval=0, o=0, o_last=0, i_rdy=1 throughout, including before the first clk edge.
REQ-029 SHALL be covered by this scenario: DW=8, single word i=24'h030201 with o_rdy=1 -> o=01, 02, 03 on cycles 1, 2, 3 after the accept; o_last=1 only on cycle 3; o_dval=0 on cycle 4.
REQ-030 SHALL be covered by this scenario: i_dval held with words 030201 then 060504, o_rdy=1 -> continuous beats 01..06 with no gap; i_rdy=1 only on the accept edges (cycles 0 and 3).
REQ-031 SHALL be covered by this scenario: o_rdy=0 for 4 cycles while lane 1 (02) is presented -> o stays 02, o_dval=1, i_rdy=0; beat 03 follows the cycle after o_rdy returns high.
REQ-032 SHALL be covered by this scenario: o_rdy=0 on the lane-2 beat while i_dval=1 -> i_rdy=0, no accept; the new word is accepted on the edge where o_rdy rises.
REQ-033 SHALL be covered by this scenario: rst pulsed low after the lane-0 beat of 030201 -> o_dval falls asynchronously; next word 0C0B0A yields beats 0A, 0B, 0C.
